// File: rtl/epc_bus_ctrl.sv
// epc_bus_ctrl: bridges a registered host (EPC) bus onto a shared LCD/UART device port with
// a ready handshake, an access timeout and sticky error reporting.
module epc_bus_ctrl #(
  parameter logic [5:0]  LCD_DATA_ADDR    = 6'h00,
  parameter logic [5:0]  LCD_CONTROL_ADDR = 6'h04,
  parameter logic [5:0]  UART_DATA_ADDR   = 6'h08,
  parameter logic [5:0]  UART_STATUS_ADDR = 6'h0C,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [1:0] epc_nCS,
  input  logic [5:0] epc_addr,
  input  logic       epc_nRD,
  input  logic       epc_nWR,
  input  logic [7:0] epc_wdata,
  output logic [7:0] epc_rdata,
  output logic [1:0] epc_rdy,
  output logic       lcd_nCS,
  output logic       lcd_rs,
  input  logic       lcd_rdy,
  input  logic [7:0] lcd_rdata,
  output logic       uart_nCS,
  input  logic       uart_rdy,
  input  logic [7:0] uart_rdata,
  input  logic [7:0] uart_status,
  output logic       dev_nWR,
  output logic       dev_nRD,
  output logic [7:0] dev_wdata,
  input  logic       err_clr,
  output logic       timeout_flag,
  output logic       decode_flag,
  output logic [7:0] err_cnt
);

  // state  | meaning
  // IDLE   | waiting for a registered host strobe with a chip select low
  // ACCESS | device strobe active, waiting for device ready or timeout
  // HOLD   | epc_rdy/epc_rdata held until the host releases both strobes
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_HOLD = 2'd2} state_t;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] ncs_q;
  logic [5:0] addr_q;
  logic       nrd_q, nwr_q;
  logic [7:0] wdata_q;

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic [7:0] tmr_q, tmr_d;
  logic       rd_q, rd_d;
  logic       lcd_ncs_q, lcd_ncs_d;
  logic       uart_ncs_q, uart_ncs_d;
  logic       dev_nwr_q, dev_nwr_d;
  logic       dev_nrd_q, dev_nrd_d;
  logic [7:0] dev_wdata_q, dev_wdata_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic [1:0] epc_rdy_q, epc_rdy_d;
  logic [7:0] epc_rdata_q, epc_rdata_d;
  logic       tflag_q, tflag_d;
  logic       dflag_q, dflag_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       one_strobe, start, hit_lcd, hit_uart, hit_stat;
  logic       act_rdy;
  logic [1:0] act_bit;
  logic       dec_err, to_err, err_new;

  // Strobe regs reset low so a strobe already low at reset release is never taken as a fresh one.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ncs_q   <= 2'b11;
      addr_q  <= 6'h00;
      nrd_q   <= 1'b0;
      nwr_q   <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      ncs_q   <= epc_nCS;
      addr_q  <= epc_addr;
      nrd_q   <= epc_nRD;
      nwr_q   <= epc_nWR;
      wdata_q <= epc_wdata;
    end
  end

  assign one_strobe = nrd_q ^ nwr_q;
  assign start      = armed_q && !(nrd_q && nwr_q) && (ncs_q != 2'b11);
  assign hit_lcd    = one_strobe && (ncs_q == 2'b01) &&
                      ((addr_q == LCD_DATA_ADDR) || (addr_q == LCD_CONTROL_ADDR));
  assign hit_uart   = one_strobe && (ncs_q == 2'b10) && (addr_q == UART_DATA_ADDR);
  assign hit_stat   = one_strobe && (ncs_q == 2'b10) && (addr_q == UART_STATUS_ADDR);
  assign act_rdy    = lcd_ncs_q ? uart_rdy : lcd_rdy;
  assign act_bit    = lcd_ncs_q ? 2'b01 : 2'b10;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    rd_d        = rd_q;
    lcd_ncs_d   = lcd_ncs_q;
    uart_ncs_d  = uart_ncs_q;
    dev_nwr_d   = dev_nwr_q;
    dev_nrd_d   = dev_nrd_q;
    dev_wdata_d = dev_wdata_q;
    lcd_rs_d    = lcd_rs_q;
    epc_rdy_d   = epc_rdy_q;
    epc_rdata_d = epc_rdata_q;
    dec_err     = 1'b0;
    to_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (hit_lcd || hit_uart) begin
            state_d     = ST_ACCESS;
            tmr_d       = TMR_LOAD;
            rd_d        = !nrd_q;
            lcd_ncs_d   = !hit_lcd;
            uart_ncs_d  = !hit_uart;
            dev_nwr_d   = nwr_q;
            dev_nrd_d   = nrd_q;
            dev_wdata_d = wdata_q;
            if (hit_lcd) lcd_rs_d = (addr_q == LCD_DATA_ADDR);
          end else if (hit_stat) begin
            state_d   = ST_HOLD;
            epc_rdy_d = 2'b01;
            if (!nrd_q) epc_rdata_d = uart_status;
          end else begin
            state_d     = ST_HOLD;
            epc_rdata_d = 8'hFF;
            epc_rdy_d   = (ncs_q == 2'b11) ? 2'b01 : ~ncs_q;
            dec_err     = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Timer is still at its load value during the first cycle, which masks rdy there.
        if ((tmr_q != TMR_LOAD) && act_rdy) begin
          state_d    = ST_HOLD;
          lcd_ncs_d  = 1'b1;
          uart_ncs_d = 1'b1;
          dev_nwr_d  = 1'b1;
          dev_nrd_d  = 1'b1;
          epc_rdy_d  = act_bit;
          if (rd_q) epc_rdata_d = lcd_ncs_q ? uart_rdata : lcd_rdata;
        end else if (tmr_q == 8'd0) begin
          state_d     = ST_HOLD;
          lcd_ncs_d   = 1'b1;
          uart_ncs_d  = 1'b1;
          dev_nwr_d   = 1'b1;
          dev_nrd_d   = 1'b1;
          epc_rdy_d   = act_bit;
          epc_rdata_d = 8'hFF;
          to_err      = 1'b1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (nrd_q && nwr_q) begin
          state_d   = ST_IDLE;
          epc_rdy_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    armed_d = armed_q | (nrd_q & nwr_q);
    err_new = dec_err | to_err;

    tflag_d   = to_err  ? 1'b1 : (err_clr ? 1'b0 : tflag_q);
    dflag_d   = dec_err ? 1'b1 : (err_clr ? 1'b0 : dflag_q);
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = err_new ? 8'd1 : 8'd0;
    else if (err_new && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      tmr_q       <= 8'd0;
      rd_q        <= 1'b0;
      lcd_ncs_q   <= 1'b1;
      uart_ncs_q  <= 1'b1;
      dev_nwr_q   <= 1'b1;
      dev_nrd_q   <= 1'b1;
      dev_wdata_q <= 8'h00;
      lcd_rs_q    <= 1'b0;
      epc_rdy_q   <= 2'b00;
      epc_rdata_q <= 8'h00;
      tflag_q     <= 1'b0;
      dflag_q     <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      tmr_q       <= tmr_d;
      rd_q        <= rd_d;
      lcd_ncs_q   <= lcd_ncs_d;
      uart_ncs_q  <= uart_ncs_d;
      dev_nwr_q   <= dev_nwr_d;
      dev_nrd_q   <= dev_nrd_d;
      dev_wdata_q <= dev_wdata_d;
      lcd_rs_q    <= lcd_rs_d;
      epc_rdy_q   <= epc_rdy_d;
      epc_rdata_q <= epc_rdata_d;
      tflag_q     <= tflag_d;
      dflag_q     <= dflag_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign epc_rdata    = epc_rdata_q;
  assign epc_rdy      = epc_rdy_q;
  assign lcd_nCS      = lcd_ncs_q;
  assign lcd_rs       = lcd_rs_q;
  assign uart_nCS     = uart_ncs_q;
  assign dev_nWR      = dev_nwr_q;
  assign dev_nRD      = dev_nrd_q;
  assign dev_wdata    = dev_wdata_q;
  assign timeout_flag = tflag_q;
  assign decode_flag  = dflag_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_epc_bus_ctrl.sv
// Bench for epc_bus_ctrl: directed host transactions plus randomized ones, each compared
// against a transaction-level model of decode, handshake timing, timeout and error counting.
module tb_epc_bus_ctrl;

  localparam int TMO = 8;
  localparam logic [5:0] A_LCD_D  = 6'h00;
  localparam logic [5:0] A_LCD_C  = 6'h04;
  localparam logic [5:0] A_UART_D = 6'h08;
  localparam logic [5:0] A_STAT   = 6'h0C;

  logic       clk = 1'b0;
  logic       nRst;
  logic [1:0] epc_nCS;
  logic [5:0] epc_addr;
  logic       epc_nRD, epc_nWR;
  logic [7:0] epc_wdata;
  logic [7:0] epc_rdata;
  logic [1:0] epc_rdy;
  logic       lcd_nCS, lcd_rs, lcd_rdy;
  logic [7:0] lcd_rdata;
  logic       uart_nCS, uart_rdy;
  logic [7:0] uart_rdata, uart_status;
  logic       dev_nWR, dev_nRD;
  logic [7:0] dev_wdata;
  logic       err_clr;
  logic       timeout_flag, decode_flag;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_rdata;
  logic       m_tflag, m_dflag;
  int         m_cnt;

  epc_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nRst(nRst),
    .epc_nCS(epc_nCS), .epc_addr(epc_addr), .epc_nRD(epc_nRD), .epc_nWR(epc_nWR),
    .epc_wdata(epc_wdata), .epc_rdata(epc_rdata), .epc_rdy(epc_rdy),
    .lcd_nCS(lcd_nCS), .lcd_rs(lcd_rs), .lcd_rdy(lcd_rdy), .lcd_rdata(lcd_rdata),
    .uart_nCS(uart_nCS), .uart_rdy(uart_rdy), .uart_rdata(uart_rdata), .uart_status(uart_status),
    .dev_nWR(dev_nWR), .dev_nRD(dev_nRD), .dev_wdata(dev_wdata),
    .err_clr(err_clr), .timeout_flag(timeout_flag), .decode_flag(decode_flag), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_strobes"}, {lcd_nCS, uart_nCS, dev_nWR, dev_nRD}, 4'hF);
    check_eq({tag, "_rdy"}, epc_rdy, 2'b00);
    check_eq({tag, "_rdata"}, epc_rdata, 8'h00);
    check_eq({tag, "_wdata_rs"}, {dev_wdata, lcd_rs}, 9'h000);
    check_eq({tag, "_flags"}, {timeout_flag, decode_flag, err_cnt}, 10'h000);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_tflag = 1'b0; m_dflag = 1'b0; m_cnt = 0;
    @(negedge clk);
    check_eq("clr_flags", {timeout_flag, decode_flag}, {m_tflag, m_dflag});
    check_eq("clr_cnt", err_cnt, m_cnt);
  endtask

  // One host transaction starting at a negedge. lat: device rdy rises in the lat-th
  // cycle of its chip select (0 = already high, 255 = never). dval < 0 randomizes device data.
  task automatic run_txn(input logic [1:0] ncs, input logic [5:0] addr, input logic nrd,
                         input logic nwr, input logic [7:0] wdata, input int lat,
                         input bit clr, input int dval);
    int kind, c, want_k, got_k, h, lcd_lo, uart_lo, wr_lo, rd_lo, dev_cnt;
    logic [1:0] want_rdy;
    logic [7:0] want_rdata, lrd, urd, ust, wd_seen;
    logic rs_seen;
    bit is_rd, to, dev, bad, held_ok;

    lrd = (dval < 0) ? 8'($urandom) : 8'(dval);
    urd = (dval < 0) ? 8'($urandom) : 8'(dval);
    ust = (dval < 0) ? 8'($urandom) : 8'(dval);
    lcd_rdata = lrd; uart_rdata = urd; uart_status = ust;
    is_rd = !nrd;

    if ((nrd ^ nwr) && ncs == 2'b01 && (addr == A_LCD_D || addr == A_LCD_C)) kind = 1;
    else if ((nrd ^ nwr) && ncs == 2'b10 && addr == A_UART_D) kind = 2;
    else if ((nrd ^ nwr) && ncs == 2'b10 && addr == A_STAT) kind = 3;
    else kind = 0;
    dev = (kind == 1) || (kind == 2);

    c = 0; to = 0;
    if (dev) begin
      c = (lat > 2) ? lat : 2;
      if (c > TMO) begin c = TMO; to = 1; end
      want_k     = c + 2;
      want_rdy   = (kind == 1) ? 2'b10 : 2'b01;
      want_rdata = to ? 8'hFF : (is_rd ? ((kind == 1) ? lrd : urd) : m_rdata);
    end else if (kind == 3) begin
      want_k     = 2;
      want_rdy   = 2'b01;
      want_rdata = is_rd ? ust : m_rdata;
    end else begin
      want_k     = 2;
      want_rdy   = ~ncs;
      want_rdata = 8'hFF;
    end
    if (clr) begin m_tflag = 0; m_dflag = 0; m_cnt = 0; end
    if (to) m_tflag = 1;
    if (kind == 0) m_dflag = 1;
    if ((to || kind == 0) && m_cnt < 255) m_cnt++;
    m_rdata = want_rdata;

    lcd_rdy  = (kind == 1) ? (lat == 0) : 1'b1;
    uart_rdy = (kind == 2) ? (lat == 0) : 1'b1;
    epc_nCS = ncs; epc_addr = addr; epc_nRD = nrd; epc_nWR = nwr; epc_wdata = wdata;

    got_k = 0; lcd_lo = 0; uart_lo = 0; wr_lo = 0; rd_lo = 0; dev_cnt = 0;
    bad = 0; rs_seen = 1'b0; wd_seen = 8'h00;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      err_clr = (k == 1) ? clr : 1'b0;
      if (!lcd_nCS && !uart_nCS) bad = 1;
      if (!dev_nWR && !dev_nRD) bad = 1;
      if (!lcd_nCS) lcd_lo++;
      if (!uart_nCS) uart_lo++;
      if (!dev_nWR) wr_lo++;
      if (!dev_nRD) rd_lo++;
      if (!dev_nWR || !dev_nRD) begin rs_seen = lcd_rs; wd_seen = dev_wdata; end
      if (epc_rdy != 2'b00) begin got_k = k; break; end
      if (kind == 1 && !lcd_nCS) begin dev_cnt++; lcd_rdy = (dev_cnt >= lat); end
      if (kind == 2 && !uart_nCS) begin dev_cnt++; uart_rdy = (dev_cnt >= lat); end
    end
    err_clr = 1'b0;

    check_eq("latency", got_k, want_k);
    check_eq("epc_rdy", epc_rdy, want_rdy);
    check_eq("epc_rdata", epc_rdata, want_rdata);
    check_eq("lcd_cs_len", lcd_lo, (kind == 1) ? c : 0);
    check_eq("uart_cs_len", uart_lo, (kind == 2) ? c : 0);
    check_eq("dev_wr_len", wr_lo, (dev && !nwr) ? c : 0);
    check_eq("dev_rd_len", rd_lo, (dev && !nrd) ? c : 0);
    check_eq("exclusive", bad, 0);
    if (dev) check_eq("dev_wdata", wd_seen, wdata);
    if (kind == 1) check_eq("lcd_rs", rs_seen, addr == A_LCD_D);

    held_ok = 1;
    h = $urandom_range(0, 2);
    repeat (h) begin
      @(negedge clk);
      if (epc_rdy !== want_rdy || epc_rdata !== want_rdata) held_ok = 0;
    end
    epc_nRD = 1'b1; epc_nWR = 1'b1; epc_nCS = 2'b11;
    lcd_rdy = 1'b0; uart_rdy = 1'b0;
    @(negedge clk);
    if (epc_rdy !== want_rdy) held_ok = 0;
    check_eq("hold", held_ok, 1);
    @(negedge clk);
    check_eq("rdy_drop", epc_rdy, 2'b00);
    check_eq("rdata_keep", epc_rdata, want_rdata);
    check_eq("flags", {timeout_flag, decode_flag}, {m_tflag, m_dflag});
    check_eq("err_cnt", err_cnt, m_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ncs;
    logic [5:0] addr;
    logic       nrd, nwr;
    int         lat, r;
    bit         stuck;

    nRst = 1'b1; err_clr = 1'b0;
    epc_nCS = 2'b11; epc_addr = 6'h00; epc_nRD = 1'b1; epc_nWR = 1'b1; epc_wdata = 8'h00;
    lcd_rdy = 1'b0; uart_rdy = 1'b0; lcd_rdata = 8'h00; uart_rdata = 8'h00; uart_status = 8'h00;
    m_rdata = 8'h00; m_tflag = 1'b0; m_dflag = 1'b0; m_cnt = 0;

    #5 nRst = 1'b0;
    #20 check_reset_vals("rst");
    @(negedge clk); nRst = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(2'b01, A_LCD_D, 1'b1, 1'b0, 8'h41, 3, 1'b0, -1);    // LCD data write
    run_txn(2'b10, A_STAT, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h5A);  // status read
    run_txn(2'b10, A_STAT, 1'b1, 1'b0, 8'h99, 0, 1'b0, -1);     // status write discarded
    run_txn(2'b01, A_LCD_C, 1'b0, 1'b1, 8'h00, 255, 1'b0, -1);  // timeout
    run_txn(2'b01, A_UART_D, 1'b1, 1'b0, 8'h77, 0, 1'b0, -1);   // decode error
    pulse_clr();
    run_txn(2'b10, A_UART_D, 1'b0, 1'b1, 8'h00, TMO, 1'b0, -1);     // rdy on last cycle
    run_txn(2'b10, A_UART_D, 1'b1, 1'b0, 8'hA5, TMO + 1, 1'b0, -1); // one past the limit
    run_txn(2'b01, A_LCD_C, 1'b0, 1'b1, 8'h00, 0, 1'b0, -1);        // rdy stuck high
    run_txn(2'b10, A_UART_D, 1'b0, 1'b0, 8'h00, 0, 1'b0, -1);       // both strobes low
    run_txn(2'b00, A_LCD_D, 1'b1, 1'b0, 8'h12, 0, 1'b1, -1);        // clear vs new error

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 2);
      ncs = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b10);
      addr = (r == 2) ? A_LCD_D : A_UART_D;
      run_txn(ncs, addr, 1'b1, 1'b0, 8'($urandom), 0, 1'b0, -1);
    end
    check_eq("saturate", err_cnt, 8'hFF);
    pulse_clr();

    // reset in the middle of a UART write, host strobe kept low across the reset
    epc_nCS = 2'b10; epc_addr = A_UART_D; epc_nWR = 1'b0; epc_nRD = 1'b1; epc_wdata = 8'h3C;
    uart_rdy = 1'b0; lcd_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_pre_cs", uart_nCS, 1'b0);
    #3 nRst = 1'b0;
    #1;
    check_eq("rst_async_cs", uart_nCS, 1'b1);
    check_eq("rst_async_wr", dev_nWR, 1'b1);
    check_eq("rst_async_rdy", epc_rdy, 2'b00);
    @(negedge clk); nRst = 1'b1;
    m_rdata = 8'h00; m_tflag = 1'b0; m_dflag = 1'b0; m_cnt = 0;
    stuck = 0;
    repeat (5) begin
      @(negedge clk);
      if (!uart_nCS || !lcd_nCS || !dev_nWR || epc_rdy != 2'b00) stuck = 1;
    end
    check_eq("rst_rearm", stuck, 0);
    check_reset_vals("post_rst");
    epc_nWR = 1'b1; epc_nCS = 2'b11; lcd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(2'b10, A_UART_D, 1'b1, 1'b0, 8'hC3, 2, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      ncs = (r < 4) ? 2'b01 : ((r < 8) ? 2'b10 : 2'b00);
      r = $urandom_range(0, 9);
      addr = (r < 2) ? A_LCD_D : (r < 4) ? A_LCD_C : (r < 6) ? A_UART_D :
             (r < 8) ? A_STAT : 6'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) {nrd, nwr} = 2'b00;
      else if (r < 6) {nrd, nwr} = 2'b01;
      else {nrd, nwr} = 2'b10;
      r = $urandom_range(0, 11);
      lat = (r == 11) ? 255 : r;
      run_txn(ncs, addr, nrd, nwr, 8'($urandom), lat, $urandom_range(0, 7) == 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
